mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one main-memory port between the CPU's instruction-fetch path and its data-access path. It sits between the CPU (or its I/D caches) and the single main-memory model. It serializes requests with the team's READ/WRITE/BUSYWAIT handshake and returns read data on a registered output per port.

## Interface
- BLOCK_ADDR_W, 6: main-memory block address width.
- BLOCK_W, 32: data block width in bits.

- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I_READ  in  1  instruction-side read request.
- I_ADDRESS  in  BLOCK_ADDR_W  instruction block address.
- I_READDATA  out  BLOCK_W  instruction read data, registered.
- I_BUSYWAIT  out  1  instruction-side stall.
- D_READ  in  1  data-side read request.
- D_WRITE  in  1  data-side write request.
- D_ADDRESS  in  BLOCK_ADDR_W  data block address.
- D_WRITEDATA  in  BLOCK_W  data write data.
- D_READDATA  out  BLOCK_W  data read data, registered.
- D_BUSYWAIT  out  1  data-side stall.
- M_READ  out  1  memory read strobe.
- M_WRITE  out  1  memory write strobe.
- M_ADDRESS  out  BLOCK_ADDR_W  memory address.
- M_WRITEDATA  out  BLOCK_W  memory write data.
- M_READDATA  in  BLOCK_W  memory read data.
- M_BUSYWAIT  in  1  memory busy.

## Operation
- Requests:
  - I_req = I_READ.
  - D_req = D_READ | D_WRITE.
  - D_READ and D_WRITE both high is treated as a write.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
  - IDLE: arbitrate. A winner moves the FSM to SERVE_x at the edge. The edge also latches the winner's address, write data and op into registers.
  - SERVE_x: drive M_READ/M_WRITE, M_ADDRESS and M_WRITEDATA from the latched registers. Completion is the first edge in SERVE_x, from the second SERVE cycle on, at which M_BUSYWAIT samples 0.
  - At completion: a read loads M_READDATA into x_READDATA. Set x_done, then go to RELEASE.
  - RELEASE: memory strobes low for one cycle, no grant, then IDLE.
- x_BUSYWAIT = x_req & ~x_done (combinational). x_done is a one-cycle pulse, cleared at the next edge. The requester therefore sees BUSYWAIT low for exactly the RELEASE cycle.
- Writes leave D_READDATA unchanged. Each READDATA holds its value until the next read completion on that port.
- A request dropped during SERVE still completes. Its read data is still written to READDATA.
- Default arbitration (fixed priority): D wins when both request in IDLE.

## Timing
- Reset (asynchronous, active-low) forces:
  - state IDLE;
  - all M_* outputs 0;
  - I_READDATA and D_READDATA 0;
  - x_done 0;
  - last_grant = I.
- Outputs go to reset values immediately, without waiting for CLK, including mid-transaction. The interrupted memory access is abandoned.
- Cycle count, with the request seen at edge 0 and memory holding busy for N cycles:
  - M strobes are high from edge 0 to the completion edge, for N+1 cycles.
  - BUSYWAIT is low in the cycle after completion.
  - Total stall is N+2 cycles.
- Back-to-back service: the earliest next grant is the edge that ends RELEASE. A waiting requester keeps BUSYWAIT high throughout.
- M_ADDRESS and M_WRITEDATA are stable while the strobe is high. Request-side inputs are not sampled after the grant edge.

## Configuration
- MEM_ARB_RR_EN defined:
  - round-robin arbitration;
  - on contention, grant the port not in last_grant;
  - last_grant updates at every grant edge.
- MEM_ARB_RR_EN undefined:
  - fixed data-over-instruction priority;
  - last_grant is not implemented.

## Structure
- Package mem_arb_pkg holds:
  - state encoding (IDLE, SERVE_I, SERVE_D, RELEASE) as a typedef;
  - the port-id typedef (PORT_I, PORT_D);
  - default width constants.
- Sub-module mem_arb_pick: combinational grant decision.
  - Inputs: I_req, D_req, last_grant.
  - Output: valid, winner.
  - Holds the only MEM_ARB_RR_EN ifdef.

## Test plan
- Instruction read alone:
  - Stimulus: I_READ=1, I_ADDRESS=6'h05, memory returns 32'hDEADBEEF after 5 busy cycles.
  - Required: M_READ high 6 cycles, I_BUSYWAIT low exactly 1 cycle, I_READDATA=32'hDEADBEEF.
- Data write:
  - Stimulus: D_WRITE=1, D_ADDRESS=6'h10, D_WRITEDATA=32'h12345678.
  - Required: M_WRITE high with M_ADDRESS=6'h10 and M_WRITEDATA=32'h12345678; D_READDATA unchanged; M_READ stays 0.
- Contention, fixed priority:
  - Stimulus: I_READ and D_READ rise on the same edge.
  - Required: D served first, then I served starting at the edge that ends RELEASE; I_BUSYWAIT high throughout the D transaction.
- Contention, MEM_ARB_RR_EN defined:
  - Stimulus: three simultaneous I/D request rounds.
  - Required: grant order D, I, D.
- Reset mid-transaction:
  - Stimulus: RESET=0 during SERVE_D, between clock edges.
  - Required: M_WRITE/M_READ and both READDATA outputs go to 0 immediately; after release the FSM is in IDLE and a fresh read completes normally.
- Simultaneous D_READ and D_WRITE:
  - Required: M_WRITE=1, M_READ=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width constants for the two-port main-memory arbiter.
package mem_arb_pkg;

    localparam int BLOCK_ADDR_W = 6;
    localparam int BLOCK_W      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_if.sv
// CPU-side (I/D) and memory-side handshake bundle of mem_arbiter.
// slave = arbiter view; master = CPU plus memory environment view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                    i_read;
    logic [BLOCK_ADDR_W-1:0] i_address;
    logic [BLOCK_W-1:0]      i_readdata;
    logic                    i_busywait;

    logic                    d_read;
    logic                    d_write;
    logic [BLOCK_ADDR_W-1:0] d_address;
    logic [BLOCK_W-1:0]      d_writedata;
    logic [BLOCK_W-1:0]      d_readdata;
    logic                    d_busywait;

    logic                    m_read;
    logic                    m_write;
    logic [BLOCK_ADDR_W-1:0] m_address;
    logic [BLOCK_W-1:0]      m_writedata;
    logic [BLOCK_W-1:0]      m_readdata;
    logic                    m_busywait;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_writedata,
               m_readdata, m_busywait,
        output i_readdata, i_busywait, d_readdata, d_busywait,
               m_read, m_write, m_address, m_writedata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_writedata,
               m_readdata, m_busywait,
        input  i_readdata, i_busywait, d_readdata, d_busywait,
               m_read, m_write, m_address, m_writedata
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arb_pick.sv
// Combinational grant decision. MEM_ARB_RR_EN selects round-robin on
// contention; otherwise the data port has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  i_req,
    input  logic  d_req,
    input  port_e last_grant,
    output logic  valid,
    output port_e winner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        valid  = i_req | d_req;
        winner = d_req ? PORT_D : PORT_I;
        if (i_req && d_req) begin
            winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        valid  = i_req | d_req;
        winner = d_req ? PORT_D : PORT_I;
    end
`endif

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between instruction and data requesters.
// Arbitration policy is set in mem_arb_pick (MEM_ARB_RR_EN = round-robin).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;

    logic                    first_q;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_W-1:0]      wdata_q;
    logic                    write_q;
    port_e                   last_grant_q;
    logic                    i_done_q, d_done_q;
    logic [BLOCK_W-1:0]      i_rdata_q, d_rdata_q;

    logic  i_req, d_req;
    logic  pick_valid;
    port_e pick_winner;
    logic  grant, complete, serving;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        grant    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                state_d = IDLE;
                if (pick_valid) begin
                    grant   = 1'b1;
                    state_d = (pick_winner == PORT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                // Memory may not have raised busywait yet on the first SERVE edge.
                if (!first_q && !bus.m_busywait) begin
                    complete = 1'b1;
                    state_d  = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            last_grant_q <= PORT_I;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            first_q  <= grant;
            i_done_q <= complete && (state_q == SERVE_I);
            d_done_q <= complete && (state_q == SERVE_D);
            if (grant) begin
                last_grant_q <= pick_winner;
                if (pick_winner == PORT_D) begin
                    addr_q  <= bus.d_address;
                    wdata_q <= bus.d_writedata;
                    write_q <= bus.d_write;
                end else begin
                    addr_q  <= bus.i_address;
                    wdata_q <= '0;
                    write_q <= 1'b0;
                end
            end
            if (complete && !write_q) begin
                if (state_q == SERVE_I) i_rdata_q <= bus.m_readdata;
                else                    d_rdata_q <= bus.m_readdata;
            end
        end
    end

    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    assign bus.m_read      = serving & ~write_q;
    assign bus.m_write     = serving &  write_q;
    assign bus.m_address   = addr_q;
    assign bus.m_writedata = wdata_q;

    assign bus.i_readdata  = i_rdata_q;
    assign bus.d_readdata  = d_rdata_q;
    assign bus.i_busywait  = i_req & ~i_done_q;
    assign bus.d_busywait  = d_req & ~d_done_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small busy-counting memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: busy for busy_n strobe cycles, then ready.
    logic [BLOCK_W-1:0] mem_model [64];
    int busy_n;
    int served;

    assign bus.m_busywait = (bus.m_read | bus.m_write) && (served < busy_n);
    assign bus.m_readdata = mem_model[bus.m_address];

    always @(posedge clk) begin
        if (bus.m_read | bus.m_write) begin
            served <= served + 1;
            if (bus.m_write && served >= busy_n) mem_model[bus.m_address] <= bus.m_writedata;
        end else begin
            served <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Runs from the request cycle until the port's busywait drops (RELEASE).
    task automatic run_txn(input bit port_d, input logic [BLOCK_ADDR_W-1:0] exp_addr,
                           input logic [BLOCK_W-1:0] exp_wdata,
                           output int rd_cyc, output int wr_cyc, output int stall, output int bad_bus);
        logic busy;
        rd_cyc = 0; wr_cyc = 0; stall = 0; bad_bus = 0;
        #1;
        for (int c = 0; c < 64; c++) begin
            busy = port_d ? bus.d_busywait : bus.i_busywait;
            if (!busy) break;
            stall++;
            if (bus.m_read)  rd_cyc++;
            if (bus.m_write) wr_cyc++;
            if ((bus.m_read | bus.m_write) &&
                (bus.m_address !== exp_addr || (bus.m_write && bus.m_writedata !== exp_wdata)))
                bad_bus++;
            tick();
        end
    endtask

    int rd, wr, st, bad;
    int d_first, i_first, d_release, i_release, i_low_during_d, win;
    bit d_finished;
    int rr_exp [3];

    initial begin
        n_vec = 0; n_err = 0;
        busy_n = 5;
        for (int a = 0; a < 64; a++) mem_model[a] = '0;
        mem_model[6'h05] = 32'hDEADBEEF;
        mem_model[6'h07] = 32'h0BADF00D;
        mem_model[6'h20] = 32'hCAFEF00D;
        mem_model[6'h21] = 32'h11223344;
        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_writedata = '0;
        rst_n = 1'b0;
        #1;
        check("rst_m_read",  32'(bus.m_read), 0);
        check("rst_m_write", 32'(bus.m_write), 0);
        check("rst_m_addr",  32'(bus.m_address), 0);
        check("rst_i_rdata", bus.i_readdata, 0);
        check("rst_d_rdata", bus.d_readdata, 0);
        check("rst_i_busy",  32'(bus.i_busywait), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Instruction read alone, memory busy 5 cycles.
        bus.i_read = 1; bus.i_address = 6'h05;
        run_txn(1'b0, 6'h05, '0, rd, wr, st, bad);
        check("ird_mread_cycles", rd, 6);
        check("ird_mwrite_cycles", wr, 0);
        check("ird_stall", st, 7);
        check("ird_bus", bad, 0);
        check("ird_data", bus.i_readdata, 32'hDEADBEEF);
        bus.i_read = 0;
        tick();
        check("ird_idle_busy", 32'(bus.i_busywait), 0);
        check("ird_idle_mread", 32'(bus.m_read), 0);
        tick();

        // Data read, busy 2.
        busy_n = 2;
        bus.d_read = 1; bus.d_address = 6'h20;
        run_txn(1'b1, 6'h20, '0, rd, wr, st, bad);
        check("drd_mread_cycles", rd, 3);
        check("drd_stall", st, 4);
        check("drd_data", bus.d_readdata, 32'hCAFEF00D);
        check("drd_i_unchanged", bus.i_readdata, 32'hDEADBEEF);
        bus.d_read = 0;
        tick(); tick();

        // Data write.
        bus.d_write = 1; bus.d_address = 6'h10; bus.d_writedata = 32'h12345678;
        run_txn(1'b1, 6'h10, 32'h12345678, rd, wr, st, bad);
        check("dwr_mwrite_cycles", wr, 3);
        check("dwr_mread_cycles", rd, 0);
        check("dwr_stall", st, 4);
        check("dwr_bus", bad, 0);
        check("dwr_rdata_kept", bus.d_readdata, 32'hCAFEF00D);
        bus.d_write = 0;
        tick();
        check("dwr_mem", mem_model[6'h10], 32'h12345678);
        tick();

        // Read back the written block, busy 1.
        busy_n = 1;
        bus.d_read = 1; bus.d_address = 6'h10;
        run_txn(1'b1, 6'h10, '0, rd, wr, st, bad);
        check("rb_mread_cycles", rd, 2);
        check("rb_data", bus.d_readdata, 32'h12345678);
        bus.d_read = 0;
        tick(); tick();

        // D_READ and D_WRITE together behave as a write.
        bus.d_read = 1; bus.d_write = 1; bus.d_address = 6'h30; bus.d_writedata = 32'hAA55AA55;
        run_txn(1'b1, 6'h30, 32'hAA55AA55, rd, wr, st, bad);
        check("rw_mwrite_cycles", wr, 2);
        check("rw_mread_cycles", rd, 0);
        check("rw_rdata_kept", bus.d_readdata, 32'h12345678);
        bus.d_read = 0; bus.d_write = 0;
        tick();
        check("rw_mem", mem_model[6'h30], 32'hAA55AA55);
        tick();

        // Reset asserted mid-transaction between edges.
        busy_n = 4;
        bus.d_write = 1; bus.d_address = 6'h3F; bus.d_writedata = 32'h00000055;
        tick(); tick();
        check("mid_pre_mwrite", 32'(bus.m_write), 1);
        rst_n = 1'b0;
        #1;
        check("mid_mwrite", 32'(bus.m_write), 0);
        check("mid_mread",  32'(bus.m_read), 0);
        check("mid_i_rdata", bus.i_readdata, 0);
        check("mid_d_rdata", bus.d_readdata, 0);
        bus.d_write = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_abandoned", mem_model[6'h3F], 0);
        check("mid_idle_mwrite", 32'(bus.m_write), 0);
        busy_n = 2;
        bus.i_read = 1; bus.i_address = 6'h07;
        run_txn(1'b0, 6'h07, '0, rd, wr, st, bad);
        check("post_rst_mread_cycles", rd, 3);
        check("post_rst_data", bus.i_readdata, 32'h0BADF00D);
        bus.i_read = 0;
        tick(); tick();

        // Contention: D first, I granted at the edge that ends RELEASE.
        busy_n = 3;
        d_first = -1; i_first = -1; d_release = -1; i_release = -1;
        i_low_during_d = 0; d_finished = 0;
        bus.i_read = 1; bus.i_address = 6'h05;
        bus.d_read = 1; bus.d_address = 6'h21;
        #1;
        for (int c = 0; c < 64; c++) begin
            if (bus.m_read && bus.m_address == 6'h21 && d_first < 0) d_first = c;
            if (bus.m_read && bus.m_address == 6'h05 && i_first < 0) i_first = c;
            if (!d_finished && !bus.i_busywait) i_low_during_d++;
            if (!d_finished && !bus.d_busywait) begin
                d_finished = 1; d_release = c; bus.d_read = 0;
            end else if (d_finished && !bus.i_busywait) begin
                i_release = c;
                break;
            end
            tick();
        end
        check("cont_d_first", d_first, 1);
        check("cont_d_release", d_release, 5);
        check("cont_i_first", i_first, 6);
        check("cont_i_release", i_release, 10);
        check("cont_i_busy_held", i_low_during_d, 0);
        check("cont_d_data", bus.d_readdata, 32'h11223344);
        check("cont_i_data", bus.i_readdata, 32'hDEADBEEF);
        bus.i_read = 0;
        tick(); tick();

        // Three simultaneous request rounds.
`ifdef MEM_ARB_RR_EN
        rr_exp = '{1, 0, 1};
`else
        rr_exp = '{1, 1, 1};
`endif
        busy_n = 1;
        for (int r = 0; r < 3; r++) begin
            bus.i_read = 1; bus.i_address = 6'h05;
            bus.d_read = 1; bus.d_address = 6'h21;
            #1;
            win = -1;
            for (int c = 0; c < 64; c++) begin
                if (!bus.d_busywait) begin win = 1; break; end
                if (!bus.i_busywait) begin win = 0; break; end
                tick();
            end
            check($sformatf("round%0d_winner", r), win, rr_exp[r]);
            bus.i_read = 0; bus.d_read = 0;
            tick(); tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
